// File: rtl/op_issue_queue_pkg.sv
// Shared types for the op_issue_queue command path: FSM states, mode type
// and the packed command word held in the FIFO.
package op_issue_queue_pkg;

    localparam int COMMAND_WIDTH = 131;

    typedef logic [2:0] mode_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_e;

    typedef struct packed {
        logic [63:0] operand1;
        logic [63:0] operand2;
        mode_t       mode;
    } command_t;

endpackage

// File: rtl/op_issue_queue_cmd_fifo.sv
// Command FIFO: power-of-two depth, pointers wrap naturally, level tracks
// occupancy so a simultaneous push and pop leaves it unchanged.
module cmd_fifo
    import op_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [COMMAND_WIDTH-1:0]   data_i,
    input  logic                       pop_i,
    output logic [COMMAND_WIDTH-1:0]   data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [COMMAND_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]              level_q, level_d;
    logic                     do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
        else if (do_pop && !do_push) level_d = level_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/op_issue_queue.sv
// Issue queue: buffers commands, issues one at a time to the arithmetic pipe,
// watches for completion with a watchdog, and holds the result until taken.
module op_issue_queue
    import op_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [63:0]             in_operand_1,
    input  logic [63:0]             in_operand_2,
    input  logic [2:0]              in_mode,
    output logic                    issue_enable,
    output logic [63:0]             issue_operand_1,
    output logic [63:0]             issue_operand_2,
    output logic [2:0]              issue_mode,
    input  logic [63:0]             core_result,
    input  logic                    core_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_result,
    output logic [2:0]              out_mode,
    output logic                    out_err,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    timeout_err
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    command_t          in_cmd, head_cmd;
    logic              fifo_full, fifo_empty, fifo_pop;
    state_e            state_q;
    logic [WDOG_W-1:0] wdog_q;
    logic              issue_enable_q, out_valid_q, out_err_q, timeout_err_q;
    logic [63:0]       issue_op1_q, issue_op2_q, out_result_q;
    mode_t             issue_mode_q, out_mode_q;

    assign in_cmd   = '{operand1: in_operand_1, operand2: in_operand_2, mode: in_mode};
    assign in_ready = !fifo_full;
    assign fifo_pop = (state_q == IDLE) && !fifo_empty;

    cmd_fifo #(.DEPTH(DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid && in_ready),
        .data_i  (in_cmd),
        .pop_i   (fifo_pop),
        .data_o  (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // core_done only matters in WAIT; a done on the final watchdog cycle wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            wdog_q         <= '0;
            issue_enable_q <= 1'b0;
            issue_op1_q    <= '0;
            issue_op2_q    <= '0;
            issue_mode_q   <= '0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_mode_q     <= '0;
            out_err_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            issue_enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        issue_op1_q    <= head_cmd.operand1;
                        issue_op2_q    <= head_cmd.operand2;
                        issue_mode_q   <= head_cmd.mode;
                        issue_enable_q <= 1'b1;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        out_result_q <= core_result;
                        out_mode_q   <= issue_mode_q;
                        out_err_q    <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= HOLD;
                    end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                        out_result_q  <= '0;
                        out_mode_q    <= issue_mode_q;
                        out_err_q     <= 1'b1;
                        timeout_err_q <= 1'b1;
                        out_valid_q   <= 1'b1;
                        state_q       <= HOLD;
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign issue_enable    = issue_enable_q;
    assign issue_operand_1 = issue_op1_q;
    assign issue_operand_2 = issue_op2_q;
    assign issue_mode      = issue_mode_q;
    assign out_valid       = out_valid_q;
    assign out_result      = out_result_q;
    assign out_mode        = out_mode_q;
    assign out_err         = out_err_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_op_issue_queue.sv
// Bench for op_issue_queue: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model built from edge timestamps.
module tb_op_issue_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [2:0]  mode;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_operand_1 = '0;
    logic [63:0] in_operand_2 = '0;
    logic [2:0]  in_mode = '0;
    logic        issue_enable;
    logic [63:0] issue_operand_1, issue_operand_2;
    logic [2:0]  issue_mode;
    logic [63:0] core_result = '0;
    logic        core_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [2:0]  out_mode;
    logic        out_err;
    logic [2:0]  level;
    logic        timeout_err;

    always #5 clk = ~clk;

    op_issue_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_operand_1    (in_operand_1),
        .in_operand_2    (in_operand_2),
        .in_mode         (in_mode),
        .issue_enable    (issue_enable),
        .issue_operand_1 (issue_operand_1),
        .issue_operand_2 (issue_operand_2),
        .issue_mode      (issue_mode),
        .core_result     (core_result),
        .core_done       (core_done),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_mode        (out_mode),
        .out_err         (out_err),
        .level           (level),
        .timeout_err     (timeout_err)
    );

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int cyc        = 0;

    // Reference model: queued commands, the one in flight, and edge stamps.
    cmd_t        modelQ[$];
    cmd_t        cur = '0;
    bit          busy = 0, finished = 0;
    int          popEdge = -100, finEdge = -100;
    logic [63:0] expResult = '0;
    logic [2:0]  expMode = '0;
    bit          expErr = 0, expSticky = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkCycle();
        checkOutput("in_ready", 64'(in_ready), 64'(modelQ.size() < DEPTH));
        checkOutput("level", 64'(level), 64'(modelQ.size()));
        checkOutput("issue_enable", 64'(issue_enable), 64'(busy && popEdge == cyc));
        checkOutput("out_valid", 64'(out_valid), 64'(busy && finished));
        checkOutput("out_err", 64'(out_err), 64'(expErr));
        checkOutput("timeout_err", 64'(timeout_err), 64'(expSticky));
        if (busy && !finished) begin
            checkOutput("issue_op1", issue_operand_1, cur.op1);
            checkOutput("issue_op2", issue_operand_2, cur.op2);
            checkOutput("issue_mode", 64'(issue_mode), 64'(cur.mode));
        end
        if (busy && finished) begin
            checkOutput("out_result", out_result, expResult);
            if (!expErr) checkOutput("out_mode", 64'(out_mode), 64'(expMode));
        end
    endtask

    // One rising edge: predict its effect from the inputs now driven, then check.
    task automatic applyStimulus();
        int   e;
        bit   popNow, acceptNow;
        cmd_t incoming;
        e = cyc + 1;
        incoming = '{op1: in_operand_1, op2: in_operand_2, mode: in_mode};
        if (!rst_n) begin
            @(posedge clk);
            #1;
            cyc = e;
            modelQ.delete();
            cur = '0; busy = 0; finished = 0; popEdge = -100; finEdge = -100;
            expResult = '0; expMode = '0; expErr = 0; expSticky = 0;
        end else begin
            popNow    = !busy && modelQ.size() > 0;
            acceptNow = in_valid && modelQ.size() < DEPTH;
            if (busy && !finished && e >= popEdge + 2) begin
                if (core_done) begin
                    finished = 1; finEdge = e;
                    expResult = core_result; expMode = cur.mode; expErr = 0;
                end else if (e == popEdge + 1 + TIMEOUT) begin
                    finished = 1; finEdge = e;
                    expResult = '0; expErr = 1; expSticky = 1;
                end
            end else if (busy && finished && e > finEdge && out_ready) begin
                busy = 0; finished = 0;
            end
            if (popNow) begin
                cur = modelQ.pop_front();
                busy = 1; finished = 0; popEdge = e;
            end
            if (acceptNow) modelQ.push_back(incoming);
            @(posedge clk);
            #1;
            cyc = e;
        end
        checkCycle();
    endtask

    task automatic pushCmd(input cmd_t c);
        bit accepted = 0;
        bit rdy;
        in_valid = 1'b1;
        in_operand_1 = c.op1; in_operand_2 = c.op2; in_mode = c.mode;
        for (int i = 0; i < 100 && !accepted; i++) begin
            rdy = in_ready;
            applyStimulus();
            accepted = rdy;
        end
        in_valid = 1'b0;
        checkOutput("push_accepted", 64'(accepted), 64'd1);
    endtask

    task automatic waitIssue(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            applyStimulus();
            seen = (issue_enable === 1'b1);
        end
        checkOutput("issue_seen", 64'(seen), 64'd1);
    endtask

    task automatic serveOne(input int delay, input logic [63:0] result);
        if (!(busy && !finished)) waitIssue(TIMEOUT);
        for (int i = 1; i < delay; i++) applyStimulus();
        core_done = 1'b1; core_result = result;
        applyStimulus();
        core_done = 1'b0;
        checkOutput("serve_valid", 64'(out_valid), 64'd1);
        checkOutput("serve_result", out_result, result);
        checkOutput("serve_err", 64'(out_err), 64'd0);
    endtask

    function automatic cmd_t randCmd();
        cmd_t c;
        c.op1  = {$urandom, $urandom};
        c.op2  = {$urandom, $urandom};
        c.mode = 3'($urandom_range(0, 7));
        return c;
    endfunction

    initial begin
        cmd_t        c;
        logic [63:0] held;
        bit          seen;
        int          peak;

        // Reset
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        checkOutput("rst_op1", issue_operand_1, 64'd0);
        checkOutput("rst_result", out_result, 64'd0);
        checkOutput("rst_mode", 64'(out_mode), 64'd0);
        applyStimulus();

        // Single command with a 5-cycle pipe latency
        out_ready = 1'b1;
        c = '{op1: 64'h3FF0000000000000, op2: 64'h4000000000000000, mode: 3'd0};
        pushCmd(c);
        waitIssue(10);
        checkOutput("single_op1", issue_operand_1, 64'h3FF0000000000000);
        checkOutput("single_op2", issue_operand_2, 64'h4000000000000000);
        serveOne(5, 64'h4008000000000000);
        checkOutput("single_result", out_result, 64'h4008000000000000);
        applyStimulus();
        applyStimulus();

        // Fill with the pipe stalled
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            c = randCmd();
            in_valid = 1'b1;
            in_operand_1 = c.op1; in_operand_2 = c.op2; in_mode = c.mode;
            applyStimulus();
            if (int'(level) > peak) peak = int'(level);
        end
        in_valid = 1'b0;
        checkOutput("fill_peak", 64'(peak), 64'd4);
        checkOutput("fill_in_ready", 64'(in_ready), 64'd0);
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            serveOne(2 + int'($urandom_range(0, 4)), {$urandom, $urandom});
            applyStimulus();
        end
        checkOutput("fill_drained", 64'(level), 64'd0);

        // Backpressure in HOLD with a second command waiting
        pushCmd(randCmd());
        pushCmd(randCmd());
        out_ready = 1'b0;
        serveOne(3, 64'hDEADBEEF01234567);
        held = out_result;
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("bp_stable", out_result, held);
        checkOutput("bp_no_issue", 64'(issue_enable), 64'd0);
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("bp_gap_idle", 64'(issue_enable), 64'd0);
        applyStimulus();
        checkOutput("bp_next_issue", 64'(issue_enable), 64'd1);
        serveOne(3, {$urandom, $urandom});
        applyStimulus();

        // Timeout, then a normal command with the sticky flag still set
        pushCmd(randCmd());
        waitIssue(10);
        seen = 0;
        for (int i = 0; i < TIMEOUT + 10 && !seen; i++) begin
            applyStimulus();
            seen = (out_valid === 1'b1);
        end
        checkOutput("to_valid", 64'(seen), 64'd1);
        checkOutput("to_err", 64'(out_err), 64'd1);
        checkOutput("to_result", out_result, 64'd0);
        checkOutput("to_sticky", 64'(timeout_err), 64'd1);
        applyStimulus();
        pushCmd(randCmd());
        serveOne(4, {$urandom, $urandom});
        checkOutput("to_sticky_after", 64'(timeout_err), 64'd1);
        applyStimulus();

        // Reset clears the sticky flag; done on the last watchdog cycle wins
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        checkOutput("rst_sticky", 64'(timeout_err), 64'd0);
        pushCmd(randCmd());
        waitIssue(10);
        for (int i = 0; i < TIMEOUT; i++) applyStimulus();
        core_done = 1'b1; core_result = 64'h0123456789ABCDEF;
        applyStimulus();
        core_done = 1'b0;
        checkOutput("race_valid", 64'(out_valid), 64'd1);
        checkOutput("race_result", out_result, 64'h0123456789ABCDEF);
        checkOutput("race_err", 64'(out_err), 64'd0);
        checkOutput("race_sticky", 64'(timeout_err), 64'd0);
        applyStimulus();

        // Reset while waiting discards the command; stale done is ignored
        pushCmd(randCmd());
        waitIssue(10);
        applyStimulus();
        applyStimulus();
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        core_done = 1'b1; core_result = {$urandom, $urandom};
        applyStimulus();
        applyStimulus();
        core_done = 1'b0;
        checkOutput("stale_valid", 64'(out_valid), 64'd0);
        checkOutput("stale_level", 64'(level), 64'd0);
        checkOutput("stale_ready", 64'(in_ready), 64'd1);

        // Random traffic, including a long stretch with the pipe silent
        for (int k = 0; k < 1500; k++) begin
            c = randCmd();
            in_valid     = ($urandom_range(0, 2) == 0);
            in_operand_1 = c.op1; in_operand_2 = c.op2; in_mode = c.mode;
            out_ready    = ($urandom_range(0, 3) != 0);
            core_done    = (k >= 600 && k < 700) ? 1'b0 : ($urandom_range(0, 5) == 0);
            core_result  = {$urandom, $urandom};
            applyStimulus();
        end
        in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b1;
        applyStimulus();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/op_issue_queue.md
OP_ISSUE_QUEUE -- requirements
Module: op_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning max cycles to wait for core_done after issue.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the command handshake.
REQ-006 SHALL have ports in_operand_1 input 64, in_operand_2 input 64 and in_mode input 3, the command payload.
REQ-007 SHALL have port issue_enable  output  1  one-cycle start pulse to the arithmetic pipe.
REQ-008 SHALL have ports issue_operand_1 output 64, issue_operand_2 output 64 and issue_mode output 3, driven to the arithmetic pipe.
REQ-009 SHALL have ports core_result input 64 and core_done input 1, the arithmetic pipe response.
REQ-010 SHALL have ports out_valid output 1 and out_ready input 1, the result handshake.
REQ-011 SHALL have ports out_result output 64, out_mode output 3 and out_err output 1, the result payload.
REQ-012 SHALL have ports level output clog2(DEPTH)+1 (FIFO occupancy) and timeout_err output 1 (sticky timeout flag).

Function
REQ-013 SHALL accept a command when in_valid and in_ready are both 1 on a rising edge; in_ready = (level < DEPTH), from registered state only.
REQ-014 SHALL store commands in a FIFO whose read and write pointers wrap modulo DEPTH.
REQ-015 SHALL keep level unchanged on a same-cycle push and pop, including when level = DEPTH-1 or level = 1.
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT and HOLD.
REQ-017 IDLE -> ISSUE when level > 0: pop the head into the issue registers.
REQ-018 ISSUE: issue_enable = 1 for exactly this one cycle, clear the watchdog, then go to WAIT.
REQ-019 WAIT: core_done = 1 captures core_result and issue_mode into out_result and out_mode, sets out_err = 0, and goes to HOLD.
REQ-020 WAIT: if the watchdog reaches TIMEOUT with no core_done, set out_result = 0, out_err = 1 and timeout_err = 1, then go to HOLD.
REQ-021 HOLD: out_valid = 1 with a stable payload; out_valid AND out_ready -> IDLE.
REQ-022 Minimum spacing between two issue_enable pulses SHALL be 4 cycles.
REQ-023 issue_operand_1, issue_operand_2 and issue_mode SHALL stay stable from ISSUE until the FSM leaves WAIT.
REQ-024 core_done SHALL be ignored in IDLE, ISSUE and HOLD.
REQ-025 core_done arriving on the same cycle as the timeout SHALL win: normal capture, no error.
REQ-026 timeout_err SHALL clear only on reset.
REQ-027 The FIFO SHALL keep accepting commands in every FSM state.

Reset
REQ-028 With rst_n = 0 at a rising edge, the block SHALL go to IDLE and clear the pointers and level.
REQ-029 Reset SHALL drive in_ready = 1 (from the next cycle), issue_enable = 0, out_valid = 0, out_err = 0 and timeout_err = 0.
REQ-030 Reset SHALL clear issue_operand_1, issue_operand_2, issue_mode, out_result and out_mode to 0.
REQ-031 Reset in the middle of WAIT SHALL discard the in-flight command; a later core_done SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the 3-bit mode type and the COMMAND_WIDTH = 131 constant.
REQ-033 The FIFO SHALL be a sub-module named cmd_fifo (parameter DEPTH, 131-bit data, push/pop/full/empty/level).
REQ-034 The FSM, watchdog and output registers SHALL reside in op_issue_queue.

Verification
REQ-035 Single command: push op1 = 64'h3FF0000000000000, op2 = 64'h4000000000000000, mode 0 -> issue_enable pulses once with these operands; model core_done 5 cycles later with result 64'h4008000000000000 -> out_valid = 1, out_result = 64'h4008000000000000, out_err = 0.
REQ-036 Fill: push 5 commands back-to-back with out_ready = 1 and the pipe stalled -> the first pops at once, level peaks at 4, in_ready = 0 while level = 4, no command is lost, and results come out in order.
REQ-037 Backpressure: hold out_ready = 0 for 10 cycles in HOLD -> payload stable, no new issue_enable; release -> IDLE -> next issue 2 cycles later.
REQ-038 Timeout: never assert core_done -> after 64 WAIT cycles, out_err = 1, out_result = 0 and timeout_err = 1; the next command completes normally with timeout_err still 1.
REQ-039 Race: core_done on the TIMEOUT cycle -> normal result, out_err = 0, timeout_err = 0.
REQ-040 Reset in WAIT: drive rst_n = 0 for 1 cycle, then a stale core_done -> out_valid stays 0, level = 0, in_ready = 1.
